qspi_responder: RTL and testbench

//  QSPI target: the memory end of the core's QSPI link. It runs on the same clock that the core

---
 rtl/qspi_pkg.sv | 21 ++
 rtl/qspi_resp_bank.sv | 42 ++++
 rtl/qspi_responder.sv | 212 +++++++++++++++++++++
 tb/tb_qspi_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// qspi_pkg: constants shared by the QSPI responder and the core's QSPI master.
//   CMD_QREAD / CMD_QWRITE : quad read / quad write command bytes
//   ADDR_NIBBLES           : address nibbles on the wire (24-bit address)
//   qspi_state_e           : responder FSM state encoding
package qspi_pkg;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } qspi_state_e;

endpackage

// File: rtl/qspi_resp_bank.sv
// qspi_resp_bank: 2^AW x 8 byte array, synchronous write, asynchronous read.
// The write port is a mux: the FSM port wins over the backdoor (the two never
// coincide in practice because the FSM only writes while a cs is low and the
// backdoor is only enabled while both cs are high).
// Ports:
//   clk        clock
//   fsm_we     FSM byte write enable
//   fsm_addr   FSM write address
//   fsm_wdata  FSM write byte
//   ld_we      backdoor write enable (already qualified by the top)
//   ld_addr    backdoor address
//   ld_data    backdoor byte
//   rd_addr    read address
//   rd_data    read byte (combinational)
module qspi_resp_bank #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          fsm_we,
    input  logic [AW-1:0] fsm_addr,
    input  logic [7:0]    fsm_wdata,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    // Contents are deliberately not reset.
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (fsm_we) begin
            mem[fsm_addr] <= fsm_wdata;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qspi_responder.sv
// qspi_responder: memory end of the core's QSPI link (flash/PSRAM stand-in).
// Decodes quad read (0xEB) and quad write (0x38) on sio, one nibble per clk,
// MS nibble first: 2 cmd nibbles, 6 address nibbles, DUMMY clocks (reads
// only), then data. cs[0] selects the read-only ROM bank, cs[1] the RAM bank.
// Optional build macro: QSPI_RESP_WRAP_EN -- burst address wraps inside an
// aligned LINE_LENGTH-byte line instead of incrementing linearly.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   cs[1:0]         active-low selects, [0]=ROM, [1]=RAM
//   sio_in[3:0]     nibble from the core
//   sio_out[3:0]    registered read nibble to the core
//   sio_oe[3:0]     responder drives sio (all bits equal)
//   ld_we/ld_bank/ld_addr/ld_data  backdoor preload, honoured only with cs==2'b11
//   busy            FSM not in IDLE
//   err             sticky error (bad cmd, ROM write, both cs low, dropped backdoor write)
//   dbg_state[2:0]  current FSM state (qspi_state_e encoding)
module qspi_responder
    import qspi_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int LINE_LENGTH = 4,
    parameter int DUMMY       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cs,
    input  logic [3:0]        sio_in,
    output logic [3:0]        sio_out,
    output logic [3:0]        sio_oe,
    input  logic              ld_we,
    input  logic              ld_bank,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              err,
    output logic [2:0]        dbg_state
);

`ifdef QSPI_RESP_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // Bits of the address that increment during a burst; the rest are held.
    localparam int              LINE_W    = $clog2(LINE_LENGTH);
    localparam logic [MEM_AW-1:0] LINE_MASK = MEM_AW'((1 << LINE_W) - 1);
    localparam logic [MEM_AW-1:0] INC_MASK  = WRAP_EN ? LINE_MASK : '1;

    qspi_state_e       state;
    logic [7:0]        cnt;
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] next_addr;
    logic [MEM_AW-1:0] rd_addr;
    logic [3:0]        cmd_hi;
    logic [3:0]        wbuf;
    logic              half;     // 0: hi nibble slot, 1: lo nibble slot
    logic              bank;     // 0=ROM, 1=RAM, latched on leaving IDLE
    logic              is_rd;
    logic              oe_r;
    logic              one_sel;
    logic              cs_idle;
    logic [7:0]        cmd_byte;
    logic [7:0]        rom_rd;
    logic [7:0]        ram_rd;
    logic [7:0]        rd_data;
    logic              fsm_we;
    logic              rom_ld_we;
    logic              ram_ld_we;

    assign one_sel   = (cs == 2'b01) || (cs == 2'b10);
    assign cs_idle   = (cs == 2'b11);
    assign cmd_byte  = {cmd_hi, sio_in};
    assign next_addr = (addr & ~INC_MASK) | ((addr + MEM_AW'(1)) & INC_MASK);

    // While the lo nibble is on the wire, fetch the byte the next hi nibble
    // will come from so it can be registered at the same edge addr advances.
    assign rd_addr = (state == ST_RDATA && half) ? next_addr : addr;
    assign rd_data = bank ? ram_rd : rom_rd;

    // The byte commits in the cycle its lo nibble arrives, only while still selected.
    assign fsm_we    = (state == ST_WDATA) && half && one_sel;
    assign rom_ld_we = ld_we && cs_idle && !ld_bank;
    assign ram_ld_we = ld_we && cs_idle && ld_bank;

    assign sio_oe    = {4{oe_r}};
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr    <= '0;
            cmd_hi  <= '0;
            wbuf    <= '0;
            half    <= 1'b0;
            bank    <= 1'b0;
            is_rd   <= 1'b0;
            oe_r    <= 1'b0;
            sio_out <= '0;
            err     <= 1'b0;
        end else begin
            if (ld_we && !cs_idle) begin
                err <= 1'b1;
            end

            if (cs_idle) begin
                state <= ST_IDLE;
                oe_r  <= 1'b0;
                half  <= 1'b0;
            end else if (cs == 2'b00) begin
                state <= ST_IGNORE;
                oe_r  <= 1'b0;
                err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_CMD;
                        bank   <= cs[0];   // cs==2'b01 means RAM selected
                        cmd_hi <= sio_in;
                    end
                    ST_CMD: begin
                        cnt <= '0;
                        if (cmd_byte == CMD_QREAD) begin
                            state <= ST_ADDR;
                            is_rd <= 1'b1;
                        end else if (cmd_byte == CMD_QWRITE && bank) begin
                            state <= ST_ADDR;
                            is_rd <= 1'b0;
                        end else begin
                            state <= ST_IGNORE;
                            err   <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        // Only the low MEM_AW bits of the 24-bit address survive.
                        addr <= {addr[MEM_AW-5:0], sio_in};
                        if (cnt == 8'(ADDR_NIBBLES - 1)) begin
                            cnt   <= '0;
                            half  <= 1'b0;
                            state <= is_rd ? ST_DUMMY : ST_WDATA;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ST_DUMMY: begin
                        if (cnt == 8'(DUMMY - 1)) begin
                            state   <= ST_RDATA;
                            oe_r    <= 1'b1;
                            sio_out <= rd_data[7:4];
                            half    <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ST_RDATA: begin
                        if (!half) begin
                            sio_out <= rd_data[3:0];
                            half    <= 1'b1;
                        end else begin
                            sio_out <= rd_data[7:4];
                            addr    <= next_addr;
                            half    <= 1'b0;
                        end
                    end
                    ST_WDATA: begin
                        if (!half) begin
                            wbuf <= sio_in;
                            half <= 1'b1;
                        end else begin
                            addr <= next_addr;
                            half <= 1'b0;
                        end
                    end
                    ST_IGNORE: begin
                        oe_r <= 1'b0;
                    end
                    default: begin
                        state <= ST_IGNORE;
                        err   <= 1'b1;
                    end
                endcase
            end
        end
    end

    qspi_resp_bank #(.AW(MEM_AW)) u_rom (
        .clk       (clk),
        .fsm_we    (1'b0),
        .fsm_addr  ('0),
        .fsm_wdata ('0),
        .ld_we     (rom_ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_addr   (rd_addr),
        .rd_data   (rom_rd)
    );

    qspi_resp_bank #(.AW(MEM_AW)) u_ram (
        .clk       (clk),
        .fsm_we    (fsm_we),
        .fsm_addr  (addr),
        .fsm_wdata ({wbuf, sio_in}),
        .ld_we     (ram_ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_addr   (rd_addr),
        .rd_data   (ram_rd)
    );

endmodule

// File: tb/tb_qspi_responder.sv
// Directed + randomized bench for qspi_responder. A byte-array model of both
// banks plus an address-sequence function predict every read nibble.
module tb_qspi_responder;

    localparam int AW   = 12;
    localparam int SIZE = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cs;
    logic [3:0]    sio_in;
    logic [3:0]    sio_out;
    logic [3:0]    sio_oe;
    logic          ld_we;
    logic          ld_bank;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          busy;
    logic          err;
    logic [2:0]    dbg_state;

    logic [7:0] rom_m [SIZE];
    logic [7:0] ram_m [SIZE];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    qspi_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sio_in    (sio_in),
        .sio_out   (sio_out),
        .sio_oe    (sio_oe),
        .ld_we     (ld_we),
        .ld_bank   (ld_bank),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Address of the i-th byte of a burst starting at base.
    function automatic int maddr(input int base, input int i);
`ifdef QSPI_RESP_WRAP_EN
        return (base - base % 4) + ((base + i) % 4);
`else
        return (base + i) % SIZE;
`endif
    endfunction

    task automatic preload(input logic b, input int a, input logic [7:0] d);
        cs      = 2'b11;
        ld_we   = 1'b1;
        ld_bank = b;
        ld_addr = AW'(a);
        ld_data = d;
        step();
        ld_we = 1'b0;
        if (b) ram_m[a] = d;
        else   rom_m[a] = d;
    endtask

    task automatic nib(input logic [3:0] n);
        sio_in = n;
        step();
    endtask

    task automatic start(input logic [1:0] c, input logic [7:0] cmd, input int a);
        logic [23:0] a24;
        a24 = 24'(a);
        cs  = c;
        nib(cmd[7:4]);
        nib(cmd[3:0]);
        for (int i = 5; i >= 0; i--) nib(a24[i*4 +: 4]);
    endtask

    task automatic do_read(input logic b, input int a, input int n);
        logic [7:0] e;
        start(b ? 2'b01 : 2'b10, 8'hEB, a);
        for (int i = 0; i < 4; i++) nib(4'($urandom_range(0, 15)));
        chk("rd_oe_first", 32'(sio_oe), 32'hF);
        for (int i = 0; i < n; i++) begin
            e = b ? ram_m[maddr(a, i)] : rom_m[maddr(a, i)];
            chk($sformatf("rd_hi b%0d a%0h i%0d", b, a, i), 32'(sio_out), 32'(e[7:4]));
            step();
            chk($sformatf("rd_lo b%0d a%0h i%0d", b, a, i), 32'(sio_out), 32'(e[3:0]));
            if (i != n - 1) step();
        end
        cs = 2'b11;
        step();
        chk("rd_end_oe", 32'(sio_oe), 32'h0);
        chk("rd_end_busy", 32'(busy), 32'h0);
    endtask

    // Nibbles come MS-first from data[63:60]; nn may be odd (lone hi nibble).
    task automatic do_write(input int a, input logic [63:0] data, input int nn);
        start(2'b01, 8'h38, a);
        for (int k = 0; k < nn; k++) nib(data[63-4*k -: 4]);
        cs = 2'b11;
        step();
        for (int j = 0; j < nn / 2; j++) ram_m[maddr(a, j)] = data[63-8*j -: 8];
    endtask

    initial begin
        reset   = 1'b1;
        cs      = 2'b11;
        sio_in  = 4'h0;
        ld_we   = 1'b0;
        ld_bank = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_oe", 32'(sio_oe), 32'h0);
        chk("reset_out", 32'(sio_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err", 32'(err), 32'h0);

        // 1: ROM read of a known line
        preload(1'b0, 12'h010, 8'hA1);
        preload(1'b0, 12'h011, 8'hB2);
        preload(1'b0, 12'h012, 8'hC3);
        preload(1'b0, 12'h013, 8'hD4);
        do_read(1'b0, 12'h010, 4);

        // 2: RAM write 5A 6B at 0x20, neighbours untouched
        preload(1'b1, 12'h01F, 8'($urandom));
        preload(1'b1, 12'h022, 8'($urandom));
        do_write(12'h020, 64'h5A6B_0000_0000_0000, 4);
        do_read(1'b1, 12'h020, 2);
        do_read(1'b1, 12'h01F, 1);
        do_read(1'b1, 12'h022, 1);

        // 3a: write command to ROM is refused
        start(2'b10, 8'h38, 12'h010);
        chk("romwr_err", 32'(err), 32'h1);
        chk("romwr_oe", 32'(sio_oe), 32'h0);
        chk("romwr_busy", 32'(busy), 32'h1);
        cs = 2'b11;
        step();
        do_read(1'b0, 12'h010, 4);

        // 3b: unknown command on RAM
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_clears_err", 32'(err), 32'h0);
        cs = 2'b01;
        nib(4'h5);
        nib(4'h5);
        chk("badcmd_err", 32'(err), 32'h1);
        chk("badcmd_busy", 32'(busy), 32'h1);
        nib(4'h0);
        chk("badcmd_oe", 32'(sio_oe), 32'h0);
        cs = 2'b11;
        step();
        chk("badcmd_idle", 32'(busy), 32'h0);

        // 4: lone hi nibble is dropped; aborted reads
        preload(1'b1, 12'h030, 8'h11);
        preload(1'b1, 12'h031, 8'($urandom));
        do_write(12'h030, 64'h7E90_0000_0000_0000, 3);
        do_read(1'b1, 12'h030, 2);
        start(2'b01, 8'hEB, 12'h030);
        nib(4'h0);
        nib(4'h0);
        cs = 2'b11;
        step();
        chk("abort_dummy_oe", 32'(sio_oe), 32'h0);
        chk("abort_dummy_busy", 32'(busy), 32'h0);
        start(2'b01, 8'hEB, 12'h030);
        for (int i = 0; i < 4; i++) nib(4'h0);
        chk("abort_rd_oe_on", 32'(sio_oe), 32'hF);
        step();
        cs = 2'b11;
        step();
        chk("abort_rd_oe_off", 32'(sio_oe), 32'h0);

        // 5: burst address sequence and bank-top rollover
        for (int a = 12'h00C; a <= 12'h013; a++) preload(1'b1, a, 8'($urandom));
        for (int a = 12'hFFC; a <= 12'hFFF; a++) preload(1'b1, a, 8'($urandom));
        for (int a = 0; a < 4; a++) preload(1'b1, a, 8'($urandom));
        do_read(1'b1, 12'h00E, 8);
        do_read(1'b1, 12'hFFF, 3);

        // randomized traffic over a preloaded window in both banks
        for (int a = 12'h100; a < 12'h140; a++) begin
            preload(1'b0, a, 8'($urandom));
            preload(1'b1, a, 8'($urandom));
        end
        for (int t = 0; t < 24; t++) begin
            int base;
            base = 12'h100 + $urandom_range(0, 12'h30);
            case ($urandom_range(0, 2))
                0: do_read(1'b0, base, $urandom_range(1, 8));
                1: do_read(1'b1, base, $urandom_range(1, 8));
                default: do_write(base, {$urandom, $urandom}, $urandom_range(1, 12));
            endcase
        end

        // 6: reset in the middle of a read burst; backdoor write while selected
        chk("pre_rst_err", 32'(err), 32'h1);
        start(2'b01, 8'hEB, 12'h100);
        for (int i = 0; i < 4; i++) nib(4'h0);
        step();
        chk("rdata_oe", 32'(sio_oe), 32'hF);
        reset = 1'b1;
        step();
        chk("rst_rd_oe", 32'(sio_oe), 32'h0);
        chk("rst_rd_busy", 32'(busy), 32'h0);
        chk("rst_rd_err", 32'(err), 32'h0);
        chk("rst_rd_out", 32'(sio_out), 32'h0);
        reset = 1'b0;
        cs    = 2'b11;
        step();
        cs      = 2'b01;
        ld_we   = 1'b1;
        ld_bank = 1'b1;
        ld_addr = AW'(12'h100);
        ld_data = ~ram_m[12'h100];
        step();
        ld_we = 1'b0;
        cs    = 2'b11;
        step();
        chk("ld_busy_err", 32'(err), 32'h1);
        do_read(1'b1, 12'h100, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
